// File: rtl/spi_frame_sync.sv
// SPI slave front end: oversamples sck/sdo, assembles MSB-first frames, and publishes
// them to the display side only on a vsync rising edge. Also returns a word on sdi.
//
// state | meaning
// IDLE  | bitcnt == 0, waiting for the first sck fall; tx word reloads every cycle
// SHIFT | bitcnt >  0, mid-frame; idle timer runs until the next sck fall
module spi_frame_sync #(
  parameter int FRAME_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  sdo,
  output logic                  sdi,
  input  logic                  vsync,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  frame_fresh,
  output logic                  rx_strobe,
  output logic                  frame_err
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sck_sync, sdo_sync, vsync_sync;
  logic                   sck_d, vsync_d;
  logic                   sck_s, sdo_s, vsync_s;

  logic [CW-1:0]         bitcnt, bitcnt_nxt;
  logic [IW-1:0]         idle, idle_nxt;
  logic [FRAME_BITS-1:0] q_sr, q_sr_nxt;
  logic [FRAME_BITS-1:0] d_sr;
  logic [FRAME_BITS-1:0] shadow;
  logic [FRAME_BITS-1:0] rx_word;
  logic                  pending;
  logic                  sck_fall, vsync_rise, in_shift, complete, timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync   <= '0;
      sdo_sync   <= '0;
      vsync_sync <= '0;
      sck_d      <= 1'b0;
      vsync_d    <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdo_sync   <= {sdo_sync[SYNC_STAGES-2:0], sdo};
      vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], vsync};
      sck_d      <= sck_s;
      vsync_d    <= vsync_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign sdo_s      = sdo_sync[SYNC_STAGES-1];
  assign vsync_s    = vsync_sync[SYNC_STAGES-1];
  assign sck_fall   = sck_d & ~sck_s;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign in_shift   = (bitcnt != '0);
  assign complete   = sck_fall && (bitcnt == LAST_BIT);
  assign timeout    = in_shift && !sck_fall && (idle == IDLE_MAX);
  assign rx_word    = {q_sr[FRAME_BITS-2:0], sdo_s};

  // An sck fall takes priority over a timeout landing on the same cycle.
  always_comb begin
    bitcnt_nxt = bitcnt;
    idle_nxt   = idle;
    q_sr_nxt   = q_sr;
    if (sck_fall) begin
      q_sr_nxt   = rx_word;
      idle_nxt   = '0;
      bitcnt_nxt = complete ? '0 : bitcnt + 1'b1;
    end else if (timeout) begin
      bitcnt_nxt = '0;
      idle_nxt   = '0;
      q_sr_nxt   = '0;
    end else if (in_shift) begin
      idle_nxt = idle + 1'b1;
    end else begin
      idle_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt      <= '0;
      idle        <= '0;
      q_sr        <= '0;
      d_sr        <= '0;
      sdi         <= 1'b0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_out   <= '0;
      frame_fresh <= 1'b0;
      rx_strobe   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      bitcnt    <= bitcnt_nxt;
      idle      <= idle_nxt;
      q_sr      <= q_sr_nxt;
      rx_strobe <= complete;
      frame_err <= timeout;

      if (sck_fall) begin
        d_sr <= d_sr << 1;
        sdi  <= d_sr[FRAME_BITS-2];
      end else if (!in_shift) begin
        d_sr <= tx_data;
        sdi  <= tx_data[FRAME_BITS-1];
      end

      // A frame completing on the vsync edge is forwarded straight to the output.
      if (vsync_rise) begin
        if (complete) begin
          shadow      <= rx_word;
          frame_out   <= rx_word;
          frame_fresh <= 1'b1;
          pending     <= 1'b0;
        end else if (pending) begin
          frame_out   <= shadow;
          frame_fresh <= 1'b1;
          pending     <= 1'b0;
        end else begin
          frame_fresh <= 1'b0;
        end
      end else if (complete) begin
        shadow  <= rx_word;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_sync.sv
// Directed bench for spi_frame_sync: table of frames plus hand-written corner sequences.
module tb_spi_frame_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        sdo = 1'b0;
  logic        sdi;
  logic        vsync = 1'b0;
  logic [31:0] tx_data = '0;
  logic [31:0] frame_out;
  logic        frame_fresh;
  logic        rx_strobe;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int err_cnt = 0;

  spi_frame_sync #(.FRAME_BITS(32), .TIMEOUT_CYCLES(4096), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdo(sdo), .sdi(sdi), .vsync(vsync),
    .tx_data(tx_data), .frame_out(frame_out), .frame_fresh(frame_fresh),
    .rx_strobe(rx_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_strobe) rx_cnt++;
    if (frame_err) err_cnt++;
  end

  typedef struct {
    logic [31:0] rx_word;
    logic [31:0] tx_word;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // sck = clk/16; sdo is set on the rise and held across the fall.
  task automatic send_bits(input logic [31:0] w, input int n, input logic change_tx,
                           output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[30:0], sdi};
      sck = 1'b1;
      sdo = w[31-i];
      tick(8);
      if (change_tx && i == 16) tx_data = ~tx_data;
      sck = 1'b0;
      tick(8);
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(6);
    vsync = 1'b0;
    tick(6);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [31:0] got;
    logic [31:0] held;
    int          rx0, err0;

    vecs[0] = '{32'hA5C3_0F12, 32'h8000_0001};
    vecs[1] = '{32'h0000_FFFF, 32'h7FFF_FFFE};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{32'h3C3C_A5A5, 32'hDEAD_BEEF};

    tick(5);
    check("reset_sdi", {31'd0, sdi}, 32'd0);
    check("reset_frame_out", frame_out, 32'd0);
    check("reset_fresh", {31'd0, frame_fresh}, 32'd0);
    reset = 1'b0;
    tick(4);

    err0 = err_cnt;
    for (int v = 0; v < 4; v++) begin
      tx_data = vecs[v].tx_word;
      tick(4);
      rx0 = rx_cnt;
      send_bits(vecs[v].rx_word, 32, 1'b1, got);
      check($sformatf("vec%0d_sdi", v), got, vecs[v].tx_word);
      check($sformatf("vec%0d_rx_strobe", v), rx_cnt - rx0, 32'd1);
      vsync_pulse();
      check($sformatf("vec%0d_frame_out", v), frame_out, vecs[v].rx_word);
      check($sformatf("vec%0d_fresh", v), {31'd0, frame_fresh}, 32'd1);
    end
    check("no_spurious_err", err_cnt - err0, 32'd0);

    // Two vsync rises with nothing new received
    held = frame_out;
    vsync_pulse();
    vsync_pulse();
    check("stale_hold", frame_out, held);
    check("stale_fresh", {31'd0, frame_fresh}, 32'd0);

    // Partial frame then timeout; next frame must realign
    err0 = err_cnt;
    rx0  = rx_cnt;
    send_bits(32'hFFC0_0000, 10, 1'b0, got);
    tick(4096 + 60);
    check("timeout_err", err_cnt - err0, 32'd1);
    check("timeout_no_rx", rx_cnt - rx0, 32'd0);
    check("timeout_out_kept", frame_out, held);
    send_bits(32'h1234_5678, 32, 1'b0, got);
    vsync_pulse();
    check("realign_frame", frame_out, 32'h1234_5678);
    check("realign_fresh", {31'd0, frame_fresh}, 32'd1);
    check("realign_err_once", err_cnt - err0, 32'd1);

    // Last sck fall coincides with vsync rise
    send_bits(32'h0BAD_F00D, 31, 1'b0, got);
    sck = 1'b1;
    sdo = 1'b1;
    tick(8);
    sck   = 1'b0;
    vsync = 1'b1;
    tick(8);
    vsync = 1'b0;
    tick(8);
    check("same_cycle_frame", frame_out, 32'h0BAD_F00D);
    check("same_cycle_fresh", {31'd0, frame_fresh}, 32'd1);
    vsync_pulse();
    check("same_cycle_next_fresh", {31'd0, frame_fresh}, 32'd0);
    check("same_cycle_next_hold", frame_out, 32'h0BAD_F00D);

    // Reset mid-frame
    tx_data = 32'hFFFF_FFFF;
    send_bits(32'hFFFF_F000, 20, 1'b0, got);
    reset = 1'b1;
    tick(4);
    check("midreset_sdi", {31'd0, sdi}, 32'd0);
    check("midreset_frame_out", frame_out, 32'd0);
    check("midreset_fresh", {31'd0, frame_fresh}, 32'd0);
    check("midreset_strobes", {30'd0, rx_strobe, frame_err}, 32'd0);
    reset = 1'b0;
    tick(4);
    rx0 = rx_cnt;
    send_bits(32'hCAFE_BABE, 32, 1'b0, got);
    check("postreset_sdi", got, 32'hFFFF_FFFF);
    check("postreset_rx", rx_cnt - rx0, 32'd1);
    vsync_pulse();
    check("postreset_frame", frame_out, 32'hCAFE_BABE);
    check("postreset_fresh", {31'd0, frame_fresh}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
